// File: rtl/alu_in_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu_in bus among NUM_REQ requesters; runs ALU reset sequence.
// Latency: accept in cycle N -> valid at N+1; backpressure: op held while ready=0, back-to-back on ready. Macro: ALU_ARB_PRIO0_EN.
module alu_in_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ALU_IN_OP_WIDTH = 8,
  parameter int RST_CYCLES      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*3-1:0]                 req_op,
  input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 alu_rst_req,
  output logic                                 alu_rst,
  input  logic                                 ready,
  output logic                                 valid,
  output logic [2:0]                           op,
  output logic [ALU_IN_OP_WIDTH-1:0]           a,
  output logic [ALU_IN_OP_WIDTH-1:0]           b,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {RST_ALU, IDLE, ISSUE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   rr_ptr;
  logic             rst_pend;

  logic [NUM_REQ-1:0] cand;
  int               win_idx;
  int               idx;
  logic             win_found;
  logic             capture;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    cand      = req_valid;
    win_idx   = 0;
    win_found = 1'b0;
    idx       = 0;
`ifdef ALU_ARB_PRIO0_EN
    cand[0] = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && cand[idx]) begin
        win_idx   = idx;
        win_found = 1'b1;
      end
    end
`ifdef ALU_ARB_PRIO0_EN
    if (req_valid[0]) begin
      win_idx   = 0;
      win_found = 1'b1;
    end
`endif
  end

  // A pending or incoming soft reset blocks new captures.
  always_comb begin
    capture = !rst && !rst_pend && !alu_rst_req && win_found &&
              ((state == IDLE) || ((state == ISSUE) && ready));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RST_ALU;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RST_ALU: if (cnt == CW'(RST_CYCLES - 1)) next_state = IDLE;
      IDLE: begin
        if (alu_rst_req || rst_pend) next_state = RST_ALU;
        else if (win_found)          next_state = ISSUE;
      end
      ISSUE: begin
        if (ready) begin
          if (alu_rst_req || rst_pend) next_state = RST_ALU;
          else if (win_found)          next_state = ISSUE;
          else                         next_state = IDLE;
        end
      end
      default: next_state = RST_ALU;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (capture) req_ready[win_idx] = 1'b1;
    busy = (state == RST_ALU) || valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      alu_rst  <= 1'b1;
      valid    <= 1'b0;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      grant_id <= '0;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      rst_pend <= 1'b0;
    end else begin
      alu_rst <= (next_state == RST_ALU);
      if (state == RST_ALU) cnt <= cnt + CW'(1);
      else                  cnt <= '0;

      if ((next_state == RST_ALU) && (state != RST_ALU))
        rst_pend <= 1'b0;
      else if (alu_rst_req && (state != RST_ALU))
        rst_pend <= 1'b1;

      if (capture) begin
        valid    <= 1'b1;
        op       <= req_op[3*win_idx +: 3];
        a        <= req_a[ALU_IN_OP_WIDTH*win_idx +: ALU_IN_OP_WIDTH];
        b        <= req_b[ALU_IN_OP_WIDTH*win_idx +: ALU_IN_OP_WIDTH];
        grant_id <= IDW'(win_idx);
`ifdef ALU_ARB_PRIO0_EN
        if (win_idx != 0) rr_ptr <= IDW'(win_idx);
`else
        rr_ptr   <= IDW'(win_idx);
`endif
      end else if ((state == ISSUE) && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_in_arbiter.sv
// Directed-vector bench for alu_in_arbiter (NUM_REQ=4, width 8, RST_CYCLES=4).
// Inputs driven on the falling edge, outputs compared 1ns later.
module tb_alu_in_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        alu_rst_req, alu_rst, ready, valid, busy;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  logic [2:0] op_tbl [4] = '{3'd5, 3'd2, 3'd1, 3'd7};
  logic [7:0] a_tbl  [4] = '{8'hA0, 8'hA1, 8'h12, 8'hA3};
  logic [7:0] b_tbl  [4] = '{8'hB0, 8'hB1, 8'h34, 8'hB3};

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       rdy;
    logic       srr;
    logic [3:0] e_rr;
    logic       e_v;
    logic [1:0] e_g;
    logic       e_arst;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  alu_in_arbiter #(.NUM_REQ(4), .ALU_IN_OP_WIDTH(8), .RST_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .alu_rst_req(alu_rst_req), .alu_rst(alu_rst), .ready(ready),
    .valid(valid), .op(op), .a(a), .b(b), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [vec %0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic [3:0] rv, input logic rdy, input logic srr,
                   input logic [3:0] e_rr, input logic e_v, input logic [1:0] e_g,
                   input logic e_arst, input logic e_busy);
    vec_t t;
    t.rst = r; t.rv = rv; t.rdy = rdy; t.srr = srr;
    t.e_rr = e_rr; t.e_v = e_v; t.e_g = e_g; t.e_arst = e_arst; t.e_busy = e_busy;
    vecs.push_back(t);
  endtask

  task automatic apply(input int i, input vec_t t);
    @(negedge clk);
    rst = t.rst; req_valid = t.rv; ready = t.rdy; alu_rst_req = t.srr;
    #1;
    check("req_ready", i, 32'(req_ready), 32'(t.e_rr));
    check("valid", i, 32'(valid), 32'(t.e_v));
    check("grant_id", i, 32'(grant_id), 32'(t.e_g));
    check("alu_rst", i, 32'(alu_rst), 32'(t.e_arst));
    check("busy", i, 32'(busy), 32'(t.e_busy));
    if (t.e_v) begin
      check("op", i, 32'(op), 32'(op_tbl[t.e_g]));
      check("a", i, 32'(a), 32'(a_tbl[t.e_g]));
      check("b", i, 32'(b), 32'(b_tbl[t.e_g]));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_op[3*i +: 3] = op_tbl[i];
      req_a[8*i +: 8]  = a_tbl[i];
      req_b[8*i +: 8]  = b_tbl[i];
    end
    rst = 1'b1; req_valid = 4'b1111; ready = 1'b0; alu_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid", -1, 32'(valid), 32'd0);
    check("rst_alu_rst", -1, 32'(alu_rst), 32'd1);
    check("rst_req_ready", -1, 32'(req_ready), 32'd0);
    check("rst_op", -1, 32'(op), 32'd0);
    check("rst_a", -1, 32'(a), 32'd0);
    check("rst_b", -1, 32'(b), 32'd0);
    check("rst_grant", -1, 32'(grant_id), 32'd0);

`ifndef ALU_ARB_PRIO0_EN
    //  rst  rv       rdy  srr  e_rr     v  g  arst busy
    // reset release: alu_rst high exactly 4 cycles, no grants
    for (int i = 0; i < 4; i++) v(0, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 1);
    v(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    // single request on requester 2
    v(0, 4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0);
    v(0, 4'b0000, 1, 0, 4'b0000, 1, 2, 0, 1);
    v(0, 4'b0000, 0, 0, 4'b0000, 0, 2, 0, 0);
    // backpressure: five stalled cycles, then back-to-back capture
    v(0, 4'b0010, 0, 0, 4'b0010, 0, 2, 0, 0);
    for (int i = 0; i < 5; i++) v(0, 4'b1000, 0, 0, 4'b0000, 1, 1, 0, 1);
    v(0, 4'b1000, 1, 0, 4'b1000, 1, 1, 0, 1);
    v(0, 4'b0000, 1, 0, 4'b0000, 1, 3, 0, 1);
    // round robin 0,1,2,3,0
    v(0, 4'b1111, 1, 0, 4'b0001, 0, 3, 0, 0);
    v(0, 4'b1111, 1, 0, 4'b0010, 1, 0, 0, 1);
    v(0, 4'b1111, 1, 0, 4'b0100, 1, 1, 0, 1);
    v(0, 4'b1111, 1, 0, 4'b1000, 1, 2, 0, 1);
    v(0, 4'b1111, 1, 0, 4'b0001, 1, 3, 0, 1);
    v(0, 4'b1111, 1, 0, 4'b0010, 1, 0, 0, 1);
    v(0, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 1);
    // soft reset while op is stalled
    v(0, 4'b0001, 0, 0, 4'b0001, 0, 1, 0, 0);
    v(0, 4'b0000, 0, 1, 4'b0000, 1, 0, 0, 1);
    v(0, 4'b1111, 0, 0, 4'b0000, 1, 0, 0, 1);
    v(0, 4'b1111, 0, 0, 4'b0000, 1, 0, 0, 1);
    v(0, 4'b1111, 1, 0, 4'b0000, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) v(0, 4'b1111, 1, 0, 4'b0000, 0, 0, 1, 1);
    v(0, 4'b1111, 1, 0, 4'b0010, 0, 0, 0, 0);
    v(0, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 1);
    // request and soft reset together in IDLE; soft reset during RST_ALU ignored
    v(0, 4'b1111, 1, 1, 4'b0000, 0, 1, 0, 0);
    v(0, 4'b1111, 1, 1, 4'b0000, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) v(0, 4'b1111, 1, 0, 4'b0000, 0, 1, 1, 1);
    v(0, 4'b0000, 1, 0, 4'b0000, 0, 1, 0, 0);
    // system reset mid-transfer drops the op
    v(0, 4'b0100, 0, 0, 4'b0100, 0, 1, 0, 0);
    v(1, 4'b0000, 0, 0, 4'b0000, 1, 2, 0, 1);
    v(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 1);
    foreach (vecs[i]) apply(i, vecs[i]);
`else
    begin
      logic [1:0] exp_g [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
      @(negedge clk);
      rst = 1'b0; req_valid = 4'b0000; ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("prio_alu_rst", 0, 32'(alu_rst), 32'd0);
      req_valid = 4'b1011;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
        req_valid = (i < 2) ? 4'b1011 : 4'b1010;
        #1;
        check("prio_valid", i, 32'(valid), 32'd1);
        check("prio_grant", i, 32'(grant_id), 32'(exp_g[i]));
        check("prio_op", i, 32'(op), 32'(op_tbl[exp_g[i]]));
        @(negedge clk);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
